// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS core's single-ported memory path: arbiter state,
// read-response tags and default geometry.
package mips_mem_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    D_LOCKED = 2'd1,
    STARVED  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_D    = 2'd2
  } rsp_tag_t;

endpackage

// File: rtl/mem_sync_ram.sv
// Single-port synchronous RAM, 1-cycle read latency, write-first on a
// same-cycle write so a store is visible to the very next read.
module mem_sync_ram
  import mips_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between instruction fetch
// (IF) and load/store (D); D has priority, bounded by starvation and lock limits.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          starved
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // Last locked grant is the one that would bring lock_cnt to LOCK_MAX-1.
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_MAX - 2);

  arb_state_t    state, state_nxt;
  rsp_tag_t      rsp_tag;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [LW-1:0] lock_cnt;
  logic          if_win, d_win;
  logic          starve_hit, lock_done;

  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    case (state)
      IDLE: begin
        d_win  = 1'b1;
        if_win = ~d_req;
      end
      STARVED:  if_win = 1'b1;
      D_LOCKED: d_win  = 1'b1;
      default: ;
    endcase
  end

  assign if_gnt = if_req & if_win;
  assign d_gnt  = d_req & d_win;

  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr : if_addr;
  assign mem_wdata = d_wdata;

  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign if_rvalid = (rsp_tag == TAG_IF);
  assign d_rvalid  = (rsp_tag == TAG_D);

  // Counter is saturating, so "reached the limit" is an equality on the next value.
  always_comb begin
    starve_nxt = '0;
    if (if_req && !if_gnt)
      starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
  end

  assign starve_hit = (starve_nxt == STARVE_MAX);
  assign lock_done  = d_gnt && (lock_cnt == LOCK_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_gnt && d_lock)  state_nxt = D_LOCKED;
        else if (starve_hit)  state_nxt = STARVED;
      end
      D_LOCKED: begin
        if (!d_lock || !d_req || lock_done)
          state_nxt = starve_hit ? STARVED : IDLE;
      end
      STARVED: begin
        if (if_gnt || !if_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lock_cnt   <= '0;
      rsp_tag    <= TAG_NONE;
      starved    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      starved    <= (state_nxt == STARVED);

      if (state_nxt != D_LOCKED)
        lock_cnt <= '0;
      else if (state == D_LOCKED && d_gnt)
        lock_cnt <= lock_cnt + 1'b1;

      if (if_gnt)              rsp_tag <= TAG_IF;
      else if (d_gnt && !d_we) rsp_tag <= TAG_D;
      else                     rsp_tag <= TAG_NONE;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter driving a mem_sync_ram; inputs change
// just after the rising edge, outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          starved;

  int n_chk  = 0;
  int n_pass = 0;
  int ng;

  always #5 clock = ~clock;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .LOCK_MAX(8)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .starved(starved)
  );

  mem_sync_ram #(.AW(AW), .DW(DW)) u_ram (
    .clock(clock), .en(mem_en), .we(mem_we), .addr(mem_addr),
    .wdata(mem_wdata), .rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic idle_in();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;
  endtask

  logic [AW-1:0] pre_addr [4];
  logic [DW-1:0] pre_data [4];

  initial begin
    pre_addr[0] = 5'd3; pre_data[0] = 32'h0C00_0000;
    pre_addr[1] = 5'd1; pre_data[1] = 32'h1111_1111;
    pre_addr[2] = 5'd5; pre_data[2] = 32'h5555_5555;
    pre_addr[3] = 5'd2; pre_data[3] = 32'h2222_2222;

    idle_in();
    mid();
    chk("rst_if_rvalid", 32'(if_rvalid), 0);
    chk("rst_d_rvalid",  32'(d_rvalid), 0);
    chk("rst_starved",   32'(starved), 0);
    chk("rst_mem_en",    32'(mem_en), 0);
    chk("rst_starve_cnt", 32'(dut.starve_cnt), 0);
    tick();
    reset = 1'b0;

    // Preload through D stores
    for (int i = 0; i < 4; i++) begin
      d_req = 1'b1; d_we = 1'b1; d_addr = pre_addr[i]; d_wdata = pre_data[i];
      mid();
      chk("pre_d_gnt",  32'(d_gnt), 1);
      chk("pre_mem_we", 32'(mem_we), 1);
      tick();
    end
    idle_in();
    mid();
    chk("store_no_rvalid", 32'(d_rvalid | if_rvalid), 0);
    tick();

    // Single IF read
    if_req = 1'b1; if_addr = 5'd3;
    mid();
    chk("if1_gnt",      32'(if_gnt), 1);
    chk("if1_d_gnt",    32'(d_gnt), 0);
    chk("if1_mem_addr", 32'(mem_addr), 3);
    chk("if1_mem_we",   32'(mem_we), 0);
    tick();
    idle_in();
    mid();
    chk("if1_rvalid", 32'(if_rvalid), 1);
    chk("if1_rdata",  if_rdata, 32'h0C00_0000);
    chk("if1_d_rvalid", 32'(d_rvalid), 0);
    tick();

    // Contention: D wins 4 cycles, then IF forced through
    if_req = 1'b1; if_addr = 5'd1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 5'd2;
    for (int c = 0; c < 5; c++) begin
      mid();
      chk("ct_d_gnt",   32'(d_gnt), 32'(c < 4));
      chk("ct_if_gnt",  32'(if_gnt), 32'(c == 4));
      chk("ct_starved", 32'(starved), 32'(c == 4));
      chk("ct_starve_cnt", 32'(dut.starve_cnt), 32'(c));
      if (c > 0) begin
        chk("ct_d_rvalid", 32'(d_rvalid), 1);
        chk("ct_d_rdata",  d_rdata, 32'h2222_2222);
      end
      tick();
    end
    idle_in();
    mid();
    chk("ct_if_rvalid", 32'(if_rvalid), 1);
    chk("ct_if_rdata",  if_rdata, 32'h1111_1111);
    chk("ct_d_rvalid_end", 32'(d_rvalid), 0);
    chk("ct_unstarved", 32'(starved), 0);
    chk("ct_cnt_clear", 32'(dut.starve_cnt), 0);
    tick();

    // Lock: D holds 8 consecutive cycles, then IF forced through
    ng = 0;
    d_req = 1'b1; d_lock = 1'b1; d_we = 1'b0; d_addr = 5'd5;
    if_req = 1'b1; if_addr = 5'd3;
    for (int c = 0; c < 12; c++) begin
      mid();
      if (c < 9) ng += int'(d_gnt);
      if (c == 1) begin
        chk("lk_d_rvalid", 32'(d_rvalid), 1);
        chk("lk_d_rdata",  d_rdata, 32'h5555_5555);
      end
      if (c == 7) chk("lk_if_refused", 32'(if_gnt), 0);
      if (c == 8) begin
        chk("lk_rel_d_gnt",  32'(d_gnt), 0);
        chk("lk_rel_if_gnt", 32'(if_gnt), 1);
        chk("lk_rel_starved", 32'(starved), 1);
      end
      if (c == 9) chk("lk_if_rvalid", 32'(if_rvalid), 1);
      tick();
    end
    chk("lk_d_gnt_count", 32'(ng), 8);
    idle_in();
    mid();
    chk("lk_end_starved", 32'(starved), 0);
    tick();
    mid();
    tick();

    // Store then load, same address
    d_req = 1'b1; d_we = 1'b1; d_addr = 5'd7; d_wdata = 32'hDEAD_BEEF;
    mid();
    chk("st_d_gnt",     32'(d_gnt), 1);
    chk("st_mem_we",    32'(mem_we), 1);
    chk("st_mem_addr",  32'(mem_addr), 7);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    d_we = 1'b0;
    mid();
    chk("ld_no_rvalid", 32'(d_rvalid | if_rvalid), 0);
    chk("ld_d_gnt",     32'(d_gnt), 1);
    chk("ld_mem_we",    32'(mem_we), 0);
    tick();
    idle_in();
    mid();
    chk("ld_d_rvalid", 32'(d_rvalid), 1);
    chk("ld_d_rdata",  d_rdata, 32'hDEAD_BEEF);
    tick();

    // Interleaved IF/D reads, no idle cycles
    for (int c = 0; c < 7; c++) begin
      idle_in();
      if (c < 6) begin
        if (c % 2 == 0) begin if_req = 1'b1; if_addr = 5'd1; end
        else begin d_req = 1'b1; d_addr = 5'd5; end
      end
      mid();
      if (c > 0) begin
        chk("il_if_rvalid", 32'(if_rvalid), 32'((c - 1) % 2 == 0));
        chk("il_d_rvalid",  32'(d_rvalid),  32'((c - 1) % 2 == 1));
        if ((c - 1) % 2 == 0) chk("il_if_rdata", if_rdata, 32'h1111_1111);
        else                  chk("il_d_rdata",  d_rdata,  32'h5555_5555);
      end
      tick();
    end

    // Reset mid-read with the port locked
    idle_in();
    d_req = 1'b1; d_lock = 1'b1; d_addr = 5'd5;
    mid();
    chk("rr_d_gnt", 32'(d_gnt), 1);
    tick();
    idle_in();
    reset = 1'b1;
    mid();
    chk("rr_d_rvalid_rst", 32'(d_rvalid), 0);
    chk("rr_starved",      32'(starved), 0);
    tick();
    reset = 1'b0;
    mid();
    chk("rr_d_rvalid_post", 32'(d_rvalid), 0);
    chk("rr_starve_cnt",    32'(dut.starve_cnt), 0);
    tick();
    if_req = 1'b1; if_addr = 5'd3;
    mid();
    chk("rr_unlocked_if_gnt", 32'(if_gnt), 1);
    tick();
    idle_in();
    mid();
    chk("rr_if_rdata", if_rdata, 32'h0C00_0000);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
